alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIRST_GRANT, default 0, requester that wins the first contested arbitration after reset (0 or 1).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-006 reqN_ready  output  1  arbiter accepts requester N's operation this cycle.
REQ-007 reqN_op  input  4  ALU operation code, same encoding as the shared ALU's alu_control.
REQ-008 reqN_a, reqN_b  input  32  operands (rs1, rs2).
REQ-009 rspN_valid  output  1  response for requester N is held.
REQ-010 rspN_ready  input  1  requester N consumes the response.
REQ-011 rspN_result  output  32  ALU result.
REQ-012 rspN_flag  output  1  branch condition result.
REQ-013 ex_en  output  1  ALU enable, high for exactly one cycle per accepted operation.
REQ-014 alu_control  output  4  op code driven to ALU.
REQ-015 rs1_data, rs2_data  output  32  operands driven to ALU.
REQ-016 alu_out  input  32  registered ALU result, valid one cycle after ex_en.
REQ-017 zero  input  1  registered ALU branch flag, valid one cycle after ex_en.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; exactly one operation is in flight at a time.
REQ-019 IDLE: reqN_ready is high only for the arbitration winner; both readies are low in EXEC and RESP.
REQ-020 Arbitration: single valid wins; both valid -> requester not granted last wins (round-robin); last_grant updates only on handshake.
REQ-021 Handshake (reqN_valid & reqN_ready) in cycle T: ex_en=1, alu_control/rs1_data/rs2_data driven combinationally from the winner in T, owner latched, next state EXEC.
REQ-022 Outside a handshake cycle, ex_en=0, alu_control=0, rs1_data=0, rs2_data=0.
REQ-023 EXEC (cycle T+1): capture alu_out and zero into the owner's response registers, next state RESP.
REQ-024 Op 0000-1001 (arith/logic/compare): rsp_result=alu_out, rsp_flag forced 0.
REQ-025 Op 1010-1111 (branch): rsp_flag=zero, rsp_result forced 0, since the ALU does not update alu_out for these ops.
REQ-026 RESP: owner's rspN_valid=1 from T+2, held with stable result/flag until rspN_ready=1; the non-owner's rsp_valid stays 0.
REQ-027 RESP with rspN_ready=1: rspN_valid falls next cycle, next state IDLE; minimum accept-to-accept spacing is 3 cycles.
REQ-028 rspN_ready while rspN_valid=0 has no effect.
REQ-029 Requester dropping reqN_valid before handshake: no operation issued, no state change.
REQ-030 Request arriving while EXEC/RESP: not accepted, waits in IDLE for arbitration.

Reset
REQ-031 reset=1 at a rising edge: state IDLE, rsp0_valid=rsp1_valid=0, rsp results/flags=0, last_grant=1-FIRST_GRANT.
REQ-032 During reset cycles: reqN_ready=0, ex_en=0, ALU outputs 0.
REQ-033 Reset in EXEC or RESP: in-flight operation discarded, no response issued; shared ALU reset from the same reset.

Verification
REQ-034 req0 add a=5,b=7 at T, rsp0_ready=1 -> ex_en=1 at T only, rsp0_valid=1 at T+2 with result=12, flag=0, ready again at T+3.
REQ-035 Both valid, back-to-back, FIRST_GRANT=0 -> grants alternate 0,1,0,1; no requester starved.
REQ-036 req1 beq a=b=0x1234 -> rsp1_flag=1, rsp1_result=0; bltu a=1,b=0xFFFFFFFF -> flag=1; blt a=1,b=0xFFFFFFFF -> flag=0.
REQ-037 rsp0_ready held 0 for 5 cycles in RESP -> rsp0_valid and result stable, req1_valid=1 gets no ready until after rsp0 consumed.
REQ-038 Reset asserted in EXEC -> next cycle rsp valids 0, state IDLE, pending request re-arbitrated after reset deasserts with FIRST_GRANT priority.
REQ-039 sub a=0,b=1 -> result 0xFFFFFFFF; sra a=0x80000000,b=4 -> 0xF8000000; sltu a=0xFFFFFFFF,b=1 -> 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared, registered ALU. One operation is in flight at a time.
// Responses are held per requester until consumed.
module alu_arbiter #(
  parameter logic FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_flag,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_flag,
  output logic        ex_en,
  output logic [3:0]  alu_control,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic [31:0] alu_out,
  input  logic        zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Op codes 1010..1111 are branch compares: the ALU only updates its zero flag for them.
  function automatic logic is_branch(input logic [3:0] op);
    return (op >= 4'b1010);
  endfunction

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_grant_q, last_grant_d;
  logic        branch_q, branch_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic [31:0] rsp0_result_q, rsp0_result_d;
  logic        rsp0_flag_q, rsp0_flag_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [31:0] rsp1_result_q, rsp1_result_d;
  logic        rsp1_flag_q, rsp1_flag_d;
  logic        grant0, grant1;

  // Round-robin grant, only offered in IDLE and never while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ALU drive: the winner's operands pass straight through in the handshake cycle, zero otherwise.
  always_comb begin
    ex_en       = 1'b0;
    alu_control = 4'd0;
    rs1_data    = 32'd0;
    rs2_data    = 32'd0;
    if (grant0) begin
      ex_en       = 1'b1;
      alu_control = req0_op;
      rs1_data    = req0_a;
      rs2_data    = req0_b;
    end else if (grant1) begin
      ex_en       = 1'b1;
      alu_control = req1_op;
      rs1_data    = req1_a;
      rs2_data    = req1_b;
    end else begin
      ex_en       = 1'b0;
      alu_control = 4'd0;
      rs1_data    = 32'd0;
      rs2_data    = 32'd0;
    end
  end

  // Next-state logic for the control FSM and per-requester response holding registers.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    branch_d      = branch_q;
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_flag_d   = rsp0_flag_q;
    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_flag_d   = rsp1_flag_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = EXEC;
          owner_d      = grant1;
          last_grant_d = grant1;
          branch_d     = is_branch(alu_control);
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d = RESP;
        // Branch ops leave alu_out stale, so the result is forced to zero for them.
        if (!owner_q) begin
          rsp0_valid_d  = 1'b1;
          rsp0_result_d = branch_q ? 32'd0 : alu_out;
          rsp0_flag_d   = branch_q ? zero : 1'b0;
        end else begin
          rsp1_valid_d  = 1'b1;
          rsp1_result_d = branch_q ? 32'd0 : alu_out;
          rsp1_flag_d   = branch_q ? zero : 1'b0;
        end
      end
      RESP: begin
        if (!owner_q && rsp0_ready) begin
          rsp0_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (owner_q && rsp1_ready) begin
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d      = IDLE;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
      end
    endcase
  end

  // State and response registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_grant_q  <= ~FIRST_GRANT;
      branch_q      <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= 32'd0;
      rsp0_flag_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= 32'd0;
      rsp1_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      branch_q      <= branch_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_flag_q   <= rsp0_flag_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_flag_q   <= rsp1_flag_d;
    end
  end

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_flag   = rsp0_flag_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_flag   = rsp1_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small registered ALU model attached to the ALU port.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_BLTU = 4'b1110;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_flag;
  logic [3:0]  req0_op;
  logic [31:0] req0_a, req0_b, rsp0_result;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_flag;
  logic [3:0]  req1_op;
  logic [31:0] req1_a, req1_b, rsp1_result;
  logic        ex_en, zero;
  logic [3:0]  alu_control;
  logic [31:0] rs1_data, rs2_data, alu_out;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.FIRST_GRANT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flag(rsp0_flag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flag(rsp1_flag),
    .ex_en(ex_en), .alu_control(alu_control),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_out(alu_out), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return a ^ b;
      4'b0101: return a << b[4:0];
      4'b0110: return a >> b[4:0];
      4'b0111: return $signed(a) >>> b[4:0];
      4'b1000: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_cond(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b1010: return a == b;
      4'b1011: return a != b;
      4'b1100: return $signed(a) < $signed(b);
      4'b1101: return $signed(a) >= $signed(b);
      4'b1110: return a < b;
      4'b1111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Shared ALU: registered, leaves alu_out untouched on branch ops, zero flags a zero result otherwise.
  always @(posedge clk) begin
    if (reset) begin
      alu_out <= 32'd0;
      zero    <= 1'b0;
    end else if (ex_en) begin
      if (alu_control >= 4'b1010) begin
        zero <= br_cond(alu_control, rs1_data, rs2_data);
      end else begin
        alu_out <= alu_calc(alu_control, rs1_data, rs2_data);
        zero    <= (alu_calc(alu_control, rs1_data, rs2_data) == 32'd0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single uncontested operation: handshake at T, EXEC at T+1, response checked at T+2 and consumed.
  task automatic do_op(input string tag, input logic who, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_flag);
    @(negedge clk);
    if (!who) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    rsp0_ready = !who;
    rsp1_ready = who;
    #1;
    chk({tag, ".idle_rsp0"}, 32'(rsp0_valid), 32'd0);
    chk({tag, ".idle_rsp1"}, 32'(rsp1_valid), 32'd0);
    chk({tag, ".ready"}, 32'(who ? req1_ready : req0_ready), 32'd1);
    chk({tag, ".other_ready"}, 32'(who ? req0_ready : req1_ready), 32'd0);
    chk({tag, ".ex_en"}, 32'(ex_en), 32'd1);
    chk({tag, ".alu_control"}, 32'(alu_control), 32'(op));
    chk({tag, ".rs1"}, rs1_data, a);
    chk({tag, ".rs2"}, rs2_data, b);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk({tag, ".exec_ex_en"}, 32'(ex_en), 32'd0);
    chk({tag, ".exec_rs1"}, rs1_data, 32'd0);
    chk({tag, ".exec_rsp_valid"}, 32'(who ? rsp1_valid : rsp0_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, ".rsp_valid"}, 32'(who ? rsp1_valid : rsp0_valid), 32'd1);
    chk({tag, ".other_rsp_valid"}, 32'(who ? rsp0_valid : rsp1_valid), 32'd0);
    chk({tag, ".result"}, who ? rsp1_result : rsp0_result, exp_res);
    chk({tag, ".flag"}, 32'(who ? rsp1_flag : rsp0_flag), 32'(exp_flag));
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0; rsp0_ready = 1'b0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0; rsp1_ready = 1'b0;

    // Reset: a request during reset is neither granted nor issued.
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst.req0_ready", 32'(req0_ready), 32'd0);
    chk("rst.ex_en", 32'(ex_en), 32'd0);
    chk("rst.alu_control", 32'(alu_control), 32'd0);
    chk("rst.rs1", rs1_data, 32'd0);
    chk("rst.rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst.rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst.rsp0_result", rsp0_result, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Arithmetic and branch ops; branch ops follow SRA so a stale alu_out must be masked.
    do_op("add", 1'b0, OP_ADD, 32'd5, 32'd7, 32'd12, 1'b0);
    do_op("sub", 1'b0, OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
    do_op("sra", 1'b0, OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    do_op("beq", 1'b1, OP_BEQ, 32'h0000_1234, 32'h0000_1234, 32'd0, 1'b1);
    do_op("bltu", 1'b1, OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    do_op("blt", 1'b1, OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    do_op("sltu", 1'b0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    do_op("sub_zero", 1'b0, OP_SUB, 32'd5, 32'd5, 32'd0, 1'b0);

    // Held response: req0 stalls consumption, req1 waits; rsp1_ready with no rsp1_valid is ignored.
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_AND; req0_a = 32'hFF00_FF00; req0_b = 32'h0F0F_0F0F;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk("hold.req0_ready", 32'(req0_ready), 32'd1);
    chk("hold.ex_en", 32'(ex_en), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F;
    rsp1_ready = 1'b1;
    #1;
    chk("hold.exec_req1_ready", 32'(req1_ready), 32'd0);
    chk("hold.exec_ex_en", 32'(ex_en), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold.rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("hold.rsp0_result", rsp0_result, 32'h0F00_0F00);
      chk("hold.req1_ready", 32'(req1_ready), 32'd0);
      chk("hold.rsp1_valid", 32'(rsp1_valid), 32'd0);
    end
    @(negedge clk);
    rsp0_ready = 1'b1;
    #1;
    chk("hold.consume_valid", 32'(rsp0_valid), 32'd1);
    chk("hold.consume_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk("hold.after_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("hold.req1_granted", 32'(req1_ready), 32'd1);
    chk("hold.req1_op", 32'(alu_control), 32'(OP_OR));
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("hold.rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("hold.rsp1_result", rsp1_result, 32'h0000_00FF);

    // No valid in IDLE: nothing is issued.
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk("quiet.ex_en", 32'(ex_en), 32'd0);
    chk("quiet.rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("quiet.req0_ready", 32'(req0_ready), 32'd0);

    // Reset during EXEC discards the in-flight op; pending requests then re-arbitrate from FIRST_GRANT.
    @(negedge clk);
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 32'd1; req1_b = 32'd2;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("rexec.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd1;
    req1_a = 32'd2; req1_b = 32'd2;
    #1;
    chk("rexec.req0_ready", 32'(req0_ready), 32'd0);
    chk("rexec.req1_ready_rst", 32'(req1_ready), 32'd0);
    chk("rexec.ex_en", 32'(ex_en), 32'd0);
    @(negedge clk);
    #1;
    chk("rexec.rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rexec.rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rexec.rsp1_result", rsp1_result, 32'd0);

    // Contested back-to-back: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rr.req0_ready", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr.req1_ready", 32'(req1_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr.rs1", rs1_data, (k % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rr.rsp_valid", 32'((k % 2 == 0) ? rsp0_valid : rsp1_valid), 32'd1);
      chk("rr.result", (k % 2 == 0) ? rsp0_result : rsp1_result, (k % 2 == 0) ? 32'd2 : 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
